// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, state encoding and index helper for the
// 61-tap FIR sequencer and its MAC unit.
//   NTAPS  number of taps (depth of coefficient and sample RAMs)
//   AW     RAM address width
//   DW     coefficient/sample width, signed Q1.15
//   ACC_W  accumulator width, signed
//   FRAC   fractional bits removed when rounding
package fir_pkg;

  localparam int NTAPS = 61;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int ACC_W = 32;
  localparam int FRAC  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Circular decrement of a sample-RAM index: 0 wraps to NTAPS-1.
  function automatic logic [AW-1:0] dec_idx(input logic [AW-1:0] idx);
    if (idx == '0) return AW'(NTAPS - 1);
    return idx - AW'(1);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: pipelined multiply-accumulate with rounding to DW bits.
// Optional feature macro: FIR_SAT_EN (clamp instead of wrap on output).
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (clears product and accumulator)
//   clr      clears the accumulator (asserted on the start handshake)
//   prod_en  loads the product register from coef*samp (RAM data valid)
//   acc_en   adds the registered product into the accumulator
//   coef     coefficient RAM read data, signed
//   samp     sample RAM read data, signed
//   result   rounded accumulator, signed DW bits
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 prod_en,
  input  logic                 acc_en,
  input  logic signed [DW-1:0] coef,
  input  logic signed [DW-1:0] samp,
  output logic        [DW-1:0] result
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (prod_en) prod <= coef * samp;
      // The accumulator wraps modulo 2**ACC_W; no overflow detection.
      if (clr)         acc <= '0;
      else if (acc_en) acc <= acc + ACC_W'(prod);
    end
  end

  // Round half up: floor((acc + 2**(FRAC-1)) / 2**FRAC) equals
  // floor(acc / 2**FRAC) plus the bit just below the binary point.
`ifdef FIR_SAT_EN
  logic [ACC_W-FRAC:0] r;
  logic                ovf;
  assign r   = {acc[ACC_W-1], acc[ACC_W-1:FRAC]} + (ACC_W-FRAC+1)'(acc[FRAC-1]);
  // r fits in DW bits only when all bits from DW-1 upward equal the sign.
  assign ovf = (r[ACC_W-FRAC:DW-1] != {(ACC_W-FRAC-DW+2){r[ACC_W-FRAC]}});

  always_comb begin
    result = r[DW-1:0];
    if (ovf) result = r[ACC_W-FRAC] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign result = acc[FRAC+DW-1:FRAC] + DW'(acc[FRAC-1]);
`endif

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: walks the coefficient RAM forward and the circular sample
// RAM backward from the newest sample, feeds fir_mac_unit and holds one
// rounded result per start request.
// Optional feature macro: FIR_SAT_EN (saturating output, see fir_mac_unit).
// Ports:
//   S_AXI_ACLK    clock
//   S_AXI_ARESET  synchronous active-high reset
//   start_valid   request one filter output
//   start_ready   high only in IDLE
//   newest_idx    sample-RAM index of newest sample, captured at start
//   coef_addr     coefficient RAM read address
//   samp_addr     sample RAM read address
//   ram_rd_en     read enable for both RAMs (data back one cycle later)
//   coef_data     coefficient RAM read data
//   samp_data     sample RAM read data
//   result_valid  rounded result available
//   result_ready  consumer accepts result
//   result_data   rounded filter output
//   busy          high in every state except IDLE
//   idx_err       one-cycle pulse when newest_idx >= NTAPS at start
//   state_dbg     current FSM state (fir_pkg::state_t encoding)
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. result_valid stays high and result_data stays stable
// until that edge; start_ready is high only in IDLE, so a start_valid
// presented while busy is simply not accepted and is not remembered.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESET,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [AW-1:0] newest_idx,
  output logic [AW-1:0] coef_addr,
  output logic [AW-1:0] samp_addr,
  output logic          ram_rd_en,
  input  logic [DW-1:0] coef_data,
  input  logic [DW-1:0] samp_data,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [DW-1:0] result_data,
  output logic          busy,
  output logic          idx_err,
  output logic [1:0]    state_dbg
);

  state_t state;
  logic   drain_cnt;
  logic   en_d1;     // RAM data valid on coef_data/samp_data
  logic   en_d2;     // registered product valid
  logic   start_hs;

  assign start_hs  = start_valid && start_ready;
  assign state_dbg = state;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state        <= IDLE;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
      idx_err      <= 1'b0;
      ram_rd_en    <= 1'b0;
      coef_addr    <= '0;
      samp_addr    <= '0;
      result_valid <= 1'b0;
      drain_cnt    <= 1'b0;
      en_d1        <= 1'b0;
      en_d2        <= 1'b0;
    end else begin
      idx_err <= 1'b0;
      en_d1   <= ram_rd_en;
      en_d2   <= en_d1;
      case (state)
        IDLE: begin
          if (start_hs) begin
            state       <= ISSUE;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            ram_rd_en   <= 1'b1;
            coef_addr   <= '0;
            // An out-of-range newest index is treated as index 0.
            if (newest_idx >= AW'(NTAPS)) begin
              samp_addr <= '0;
              idx_err   <= 1'b1;
            end else begin
              samp_addr <= newest_idx;
            end
          end
        end
        ISSUE: begin
          if (coef_addr == AW'(NTAPS - 1)) begin
            state     <= DRAIN;
            ram_rd_en <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            coef_addr <= coef_addr + AW'(1);
            samp_addr <= dec_idx(samp_addr);
          end
        end
        DRAIN: begin
          // Two cycles: last RAM read lands, then its product is accumulated.
          if (drain_cnt) begin
            state        <= HOLD;
            result_valid <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fir_mac_unit u_mac (
    .clk     (S_AXI_ACLK),
    .rst     (S_AXI_ARESET),
    .clr     (start_hs),
    .prod_en (en_d1),
    .acc_en  (en_d2),
    .coef    (coef_data),
    .samp    (samp_data),
    .result  (result_data)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: self-checking bench for fir_tap_sequencer.
// Optional feature macro: FIR_SAT_EN (must match the RTL build).
module tb_fir_tap_sequencer;

  localparam int NT = 61;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_valid, start_ready;
  logic [5:0]  newest_idx;
  logic [5:0]  coef_addr, samp_addr;
  logic        ram_rd_en;
  logic [15:0] coef_data, samp_data;
  logic        result_valid, result_ready;
  logic [15:0] result_data;
  logic        busy, idx_err;
  logic [1:0]  state_dbg;

  fir_tap_sequencer dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .newest_idx   (newest_idx),
    .coef_addr    (coef_addr),
    .samp_addr    (samp_addr),
    .ram_rd_en    (ram_rd_en),
    .coef_data    (coef_data),
    .samp_data    (samp_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .busy         (busy),
    .idx_err      (idx_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- RAM models (1-cycle read latency) ----------------
  logic signed [15:0] coef_mem [0:63];
  logic signed [15:0] samp_mem [0:63];

  always @(posedge clk) begin
    if (ram_rd_en) begin
      coef_data <= coef_mem[coef_addr];
      samp_data <= samp_mem[samp_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference: direct convolution, wrap to 32 bits, round half up.
  function automatic logic [15:0] model_result(input int n_in);
    int          n;
    longint      acc;
    logic [31:0] a32;
    longint      r;
    n   = (n_in >= NT) ? 0 : n_in;
    acc = 0;
    for (int k = 0; k < NT; k++)
      acc += longint'(coef_mem[k]) * longint'(samp_mem[(n - k + NT) % NT]);
    a32 = acc[31:0];
    r   = (longint'($signed(a32)) + 64'sd16384) >>> 15;
`ifdef FIR_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  logic [15:0] exp_q [$];
  int          cyc = 0;
  int          c0 = -1000;
  int          cur_n = 0;
  bit          cur_bad = 1'b0;
  bit          model_busy = 1'b0;
  bit          mon_on = 1'b0;
  logic [15:0] last_dut_result = '0;

  // Per-cycle compare: the expected timeline is derived from the cycle count
  // since the accepted start (reads at +1..+61, result from +64 on).
  always @(negedge clk) begin : mon
    bit res_avail;
    bit issuing;
    int k;
    cyc++;
    if (mon_on) begin
      res_avail = model_busy && (cyc - c0 >= NT + 3);
      issuing   = model_busy && (cyc - c0 >= 1) && (cyc - c0 <= NT);
      k         = cyc - c0 - 1;
      check("start_ready", start_ready, !model_busy);
      check("busy", busy, model_busy);
      check("result_valid", result_valid, res_avail);
      check("ram_rd_en", ram_rd_en, issuing);
      check("idx_err", idx_err, cur_bad && (cyc == c0 + 1));
      if (issuing) begin
        check("coef_addr", coef_addr, k);
        check("samp_addr", samp_addr, (cur_n - k + NT) % NT);
      end
      if (res_avail) begin
        if (exp_q.size() == 0) check("result_queue_empty", 1, 0);
        else check("result_data", result_data, exp_q[0]);
        last_dut_result = result_data;
      end
      // model update
      if (rst) begin
        model_busy = 1'b0;
        c0 = -1000;
        exp_q.delete();
      end else if (res_avail && result_ready) begin
        void'(exp_q.pop_front());
        model_busy = 1'b0;
      end else if (!model_busy && start_valid) begin
        c0         = cyc;
        cur_bad    = (newest_idx >= NT);
        cur_n      = cur_bad ? 0 : int'(newest_idx);
        model_busy = 1'b1;
        exp_q.push_back(model_result(cur_n));
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic clear_mems();
    for (int i = 0; i < 64; i++) begin
      coef_mem[i] = '0;
      samp_mem[i] = '0;
    end
  endtask

  task automatic random_mems();
    for (int i = 0; i < 64; i++) begin
      coef_mem[i] = 16'($urandom);
      samp_mem[i] = 16'($urandom);
    end
  endtask

  task automatic start_op(input logic [5:0] n);
    start_valid = 1'b1;
    newest_idx  = n;
    @(posedge clk); #1;
    start_valid = 1'b0;
    newest_idx  = 6'($urandom);
  endtask

  task automatic finish_op(input int hold, input bit noisy);
    int t;
    t = 0;
    while (!result_valid && t < 200) begin
      if (noisy) begin
        start_valid  = 1'($urandom_range(0, 1));
        result_ready = 1'($urandom_range(0, 1));
        newest_idx   = 6'($urandom);
      end
      @(posedge clk); #1;
      t++;
    end
    start_valid  = 1'b0;
    result_ready = 1'b0;
    if (!result_valid) check("result_valid_timeout", 0, 1);
    repeat (hold) begin
      if (noisy) start_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] n, input int hold, input bit noisy);
    start_op(n);
    finish_op(hold, noisy);
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    newest_idx   = '0;
    clear_mems();
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_idx_err", idx_err, 0);
    check("rst_ram_rd_en", ram_rd_en, 0);
    check("rst_coef_addr", coef_addr, 0);
    check("rst_samp_addr", samp_addr, 0);
    check("rst_result_data", result_data, 0);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // single tap impulse
    clear_mems();
    coef_mem[0] = 16'sh4000;
    samp_mem[5] = 16'sh2000;
    check("model_t1", model_result(5), 16'h1000);
    run_op(6'd5, 0, 1'b0);
    check("t1_result", last_dut_result, 16'h1000);

    // address wrap from newest=0
    clear_mems();
    coef_mem[1]  = 16'sh7FFF;
    samp_mem[60] = 16'sh7FFF;
    check("model_t2", model_result(0), 16'h7FFE);
    run_op(6'd0, 2, 1'b1);
    check("t2_result", last_dut_result, 16'h7FFE);

    // full-scale: accumulator wraps at 2**32
    for (int i = 0; i < NT; i++) begin
      coef_mem[i] = 16'sh7FFF;
      samp_mem[i] = 16'sh7FFF;
    end
    check("model_t3", model_result(17), 16'h7F86);
    run_op(6'd17, 1, 1'b0);
    check("t3_result", last_dut_result, 16'h7F86);

    // rounding boundary
    clear_mems();
    coef_mem[0] = 16'sh0001;
    samp_mem[7] = 16'sh4000;
    check("model_t4a", model_result(7), 16'h0001);
    run_op(6'd7, 0, 1'b0);
    check("t4a_result", last_dut_result, 16'h0001);
    samp_mem[7] = 16'sh3FFF;
    check("model_t4b", model_result(7), 16'h0000);
    run_op(6'd7, 0, 1'b0);
    check("t4b_result", last_dut_result, 16'h0000);

    // long hold with ignored starts, then back-to-back start
    random_mems();
    run_op(6'd40, 10, 1'b1);
    run_op(6'd3, 0, 1'b0);

    // reset while issuing tap 30
    random_mems();
    start_op(6'd22);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_rd_en", ram_rd_en, 0);
    check("mid_rst_result_data", result_data, 0);
    check("mid_rst_coef_addr", coef_addr, 0);
    repeat (70) @(posedge clk);
    #1;
    run_op(6'd22, 1, 1'b0);

    // out-of-range newest index behaves as index 0
    random_mems();
    run_op(6'd63, 0, 1'b0);
    check("t6_idx63_result", last_dut_result, model_result(0));

    // randomized operations
    for (int i = 0; i < 8; i++) begin
      random_mems();
      run_op(6'($urandom_range(0, 63)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
